// File: rtl/counter_seq_pkg.sv
// Purpose: shared types for the counter sequencer (FSM state encoding).
// Latency: n/a (types only).
// Backpressure: n/a.
package counter_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } seq_state_e;

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Purpose: gap prescaler; tick fires once every gap+1 enabled cycles.
// Latency: tick is combinational from the prescaler register and en.
// Backpressure: en low freezes the prescaler and suppresses tick.
//
// Ports:
//   clk, rstn : clock, async active-low reset
//   clr       : synchronous reload to zero (takes priority)
//   en        : advance enable (low = pause)
//   gap       : terminal value; tick when prescaler == gap
//   tick      : increment strobe
module tick_gen #(
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [GAP_W-1:0] gap,
  output logic             tick
);

  logic [GAP_W-1:0] r_cnt;

  assign tick = (r_cnt == gap) && en;

  // r_cnt never passes gap: it reloads on tick and holds while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Purpose: command-driven controller that clears the shared up-counter and steps it to a target.
// Latency: accept cyc 0, clear cyc 1, incr every gap+1 RUN cycles, done 1 cycle after target seen.
// Backpressure: cmd_ready only in IDLE; pause freezes stepping; abort cancels (done wins on tie).
//
// Ports:
//   clk, rstn              : clock, async active-low reset
//   cmd_valid/cmd_ready    : command handshake carrying cmd_target, cmd_gap
//   pause, abort           : freeze / cancel the active command
//   count_reg              : registered value from the counter
//   cnt_rst, cnt_incr      : counter controls (rst has priority inside the counter)
//   busy, done, aborted    : status; done/aborted are 1-cycle pulses
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] count_reg,
  output logic             cnt_rst,
  output logic             cnt_incr,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_target;
  logic [GAP_W-1:0] r_gap;
  logic             w_tick;
  logic             w_tick_clr;
  logic             w_tick_en;
  logic             w_at_target;

  // Prescaler restarts from zero every time RUN is entered.
  assign w_tick_clr  = (r_state != RUN);
  assign w_tick_en   = !pause;
  assign w_at_target = (count_reg == r_target);

  tick_gen #(.GAP_W(GAP_W)) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_tick_clr),
    .en   (w_tick_en),
    .gap  (r_gap),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_gap    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && cmd_valid) begin
        r_target <= cmd_target;
        r_gap    <= cmd_gap;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cnt_incr    = 1'b0;
    case (r_state)
      IDLE:  if (cmd_valid) w_state_nxt = CLEAR;
      CLEAR: w_state_nxt = abort ? ABORT : RUN;
      RUN: begin
        // Reaching the target beats a simultaneous abort; never step past it.
        if (w_at_target) begin
          w_state_nxt = DONE;
        end else if (abort) begin
          w_state_nxt = ABORT;
        end else begin
          cnt_incr = w_tick;
        end
      end
      DONE:    w_state_nxt = IDLE;
      ABORT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter is held clear while this block is in reset.
  assign cnt_rst   = !rstn || (r_state == CLEAR);
  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign aborted   = (r_state == ABORT);

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench: counter_sequencer driving a behavioural up-counter.
// Expected timings come from command-level arithmetic (accept, clear, ticks every gap+1).
// Inputs change just after negedge; outputs are sampled 1 time unit later.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_target;
  logic [3:0] cmd_gap;
  logic       pause;
  logic       abort;
  logic [7:0] count_reg;
  logic       cnt_rst;
  logic       cnt_incr;
  logic       busy;
  logic       done;
  logic       aborted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared counter: synchronous clear has priority over increment.
  always_ff @(posedge clk) begin
    if (cnt_rst)       count_reg <= '0;
    else if (cnt_incr) count_reg <= count_reg + 1'b1;
  end

  counter_sequencer #(.WIDTH(8), .GAP_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_gap    (cmd_gap),
    .pause      (pause),
    .abort      (abort),
    .count_reg  (count_reg),
    .cnt_rst    (cnt_rst),
    .cnt_incr   (cnt_incr),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run one command. ps/pl: pause window start/length (pl=0 none); ab: abort cycle (-1 none);
  // hold: keep cmd_valid high throughout. Cycle 0 is the handshake cycle.
  task automatic do_cmd(input string tag, input int t, input int g, input int ps,
                        input int pl, input int ab, input bit hold);
    int r, shift, exp_done, exp_ab, exp_incr;
    int done_c, ab_c, n_incr, n_rst, rst_c, first_incr, n_acc, max_cnt;
    r = 2 + t * (g + 1);  // first cycle in which count_reg == target is visible
    shift = (pl > 0 && ps >= 2 && ps < r) ? pl : 0;
    if (ab >= 1 && ab < r) begin
      exp_ab   = ab + 1;
      exp_done = -1;
      exp_incr = (ab - 3 - g < 0) ? 0 : (ab - 3 - g) / (g + 1) + 1;
    end else begin
      exp_ab   = -1;
      exp_done = r + 1 + shift;
      exp_incr = t;
    end
    done_c = -1; ab_c = -1; n_incr = 0; n_rst = 0; rst_c = -1;
    first_incr = -1; n_acc = 0; max_cnt = 0;
    cmd_target = 8'(t);
    cmd_gap    = 4'(g);
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = (c == 0) || hold;
      pause     = (c >= ps) && (c < ps + pl);
      abort     = (c == ab);
      #1;
      if (c == 0) chk({tag, "_rdy0"}, 32'(cmd_ready), 32'd1);
      else if (cmd_valid && cmd_ready) n_acc++;
      if (cnt_rst) begin n_rst++; rst_c = c; end
      if (cnt_incr) begin n_incr++; if (first_incr < 0) first_incr = c; end
      if (c >= 2 && int'(count_reg) > max_cnt) max_cnt = int'(count_reg);
      if (done) done_c = c;
      if (aborted) ab_c = c;
      @(negedge clk);
      if (done_c >= 0 || ab_c >= 0) break;
    end
    cmd_valid = hold;
    pause = 1'b0;
    abort = 1'b0;
    #1;
    chk({tag, "_done_cyc"},  32'(done_c),  32'(exp_done));
    chk({tag, "_abort_cyc"}, 32'(ab_c),    32'(exp_ab));
    chk({tag, "_n_incr"},    32'(n_incr),  32'(exp_incr));
    chk({tag, "_n_rst"},     32'(n_rst),   32'd1);
    chk({tag, "_rst_cyc"},   32'(rst_c),   32'd1);
    chk({tag, "_count"},     32'(count_reg), 32'(exp_incr));
    chk({tag, "_max_count"}, 32'(max_cnt), 32'(exp_incr));
    chk({tag, "_early_acc"}, 32'(n_acc),   32'd0);
    chk({tag, "_rdy_after"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy),   32'd0);
    if (exp_incr > 0 && pl == 0)
      chk({tag, "_first_incr"}, 32'(first_incr), 32'(2 + g));
  endtask

  initial begin
    int t, g, mode, ps, pl, ab;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_target = '0; cmd_gap = '0;
    pause = 1'b0; abort = 1'b0;
    #1;
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_cnt_rst", 32'(cnt_rst),  32'd1);
    chk("rst_incr",    32'(cnt_incr), 32'd0);
    chk("rst_done",    32'(done),     32'd0);
    chk("rst_aborted", 32'(aborted),  32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count_reg), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rstn = 1'b1;

    // Directed scenarios
    do_cmd("t1_t5g0",  5, 0, -1, 0, -1, 1'b0);
    do_cmd("t2_t3g2",  3, 2, -1, 0, -1, 1'b0);
    do_cmd("t3_t0",    0, 0, -1, 0, -1, 1'b0);
    do_cmd("t3_t255",  255, 0, -1, 0, -1, 1'b0);
    do_cmd("t4_pause", 10, 0, 6, 4, -1, 1'b0);
    do_cmd("t5_abort", 10, 0, -1, 0, 6, 1'b0);
    do_cmd("t5_tie",   3, 0, -1, 0, 5, 1'b0);
    do_cmd("t5_hold",  4, 1, -1, 0, -1, 1'b1);
    do_cmd("t5_next",  2, 0, -1, 0, -1, 1'b0);

    // Reset in the middle of a run
    cmd_valid = 1'b1; cmd_target = 8'd10; cmd_gap = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && count_reg != 8'd6; i++) @(negedge clk);
    chk("t6_count6", 32'(count_reg), 32'd6);
    rstn = 1'b0;
    #1;
    chk("t6_busy",    32'(busy),     32'd0);
    chk("t6_cnt_rst", 32'(cnt_rst),  32'd1);
    chk("t6_incr",    32'(cnt_incr), 32'd0);
    @(negedge clk);
    chk("t6_count0",  32'(count_reg), 32'd0);
    chk("t6_done",    32'(done),     32'd0);
    chk("t6_aborted", 32'(aborted),  32'd0);
    rstn = 1'b1;
    do_cmd("t6_after", 2, 0, -1, 0, -1, 1'b0);

    // Randomized commands: plain, paused, or aborted
    for (int n = 0; n < 24; n++) begin
      t = int'($urandom_range(0, 20));
      g = int'($urandom_range(0, 15));
      mode = int'($urandom_range(0, 2));
      ps = -1; pl = 0; ab = -1;
      if (mode == 1 && t > 0) begin
        ps = int'($urandom_range(2, 1 + t * (g + 1)));
        pl = int'($urandom_range(1, 6));
      end else if (mode == 2) begin
        ab = int'($urandom_range(0, 4 + t * (g + 1)));
      end
      do_cmd($sformatf("rnd%0d", n), t, g, ps, pl, ab, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
